// File: rtl/pipe_hazard_if.sv
// Bundle between the pipeline datapath and the hazard sequencer.
interface pipe_hazard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_ex_memread_i;
  logic [REG_AW-1:0] id_ex_rt_i;
  logic [REG_AW-1:0] if_id_rs_i;
  logic [REG_AW-1:0] if_id_rt_i;
  logic              branch_taken_i;
  logic              dmem_req_i;
  logic              dmem_ready_i;
  logic              pc_en_o;
  logic              if_id_en_o;
  logic              if_id_flush_o;
  logic              id_ex_en_o;
  logic              id_ex_bubble_o;
  logic              ex_mem_en_o;
  logic              mem_wb_bubble_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic              err_o;

  // Pipeline side: reports hazard sources, consumes enables/bubbles.
  modport master (
    output id_ex_memread_i, id_ex_rt_i, if_id_rs_i, if_id_rt_i,
           branch_taken_i, dmem_req_i, dmem_ready_i,
    input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_bubble_o,
           ex_mem_en_o, mem_wb_bubble_o, stall_cnt_o, err_o
  );

  // Sequencer side.
  modport slave (
    input  id_ex_memread_i, id_ex_rt_i, if_id_rs_i, if_id_rt_i,
           branch_taken_i, dmem_req_i, dmem_ready_i,
    output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_bubble_o,
           ex_mem_en_o, mem_wb_bubble_o, stall_cnt_o, err_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, data-memory
// freeze with timeout, branch flush (deferred while frozen), stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  pipe_hazard_if.slave    bus
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  stall_q;
  logic              err_q;

  logic freeze_c;
  logic load_use_c;
  logic flush_c;
  logic pc_en_c;

  // Hazard sources decoded from the current state and pipeline inputs.
  always_comb begin
    freeze_c   = 1'b0;
    load_use_c = 1'b0;
    flush_c    = 1'b0;
    if (rst_n_i) begin
      freeze_c = ((state_q == RUN) && bus.dmem_req_i && !bus.dmem_ready_i) ||
                 ((state_q == MEM_WAIT) && !bus.dmem_ready_i) ||
                 (state_q == ERROR);
      load_use_c = bus.id_ex_memread_i && (bus.id_ex_rt_i != REG_AW'(0)) &&
                   ((bus.id_ex_rt_i == bus.if_id_rs_i) ||
                    (bus.id_ex_rt_i == bus.if_id_rt_i));
      flush_c = !freeze_c && (bus.branch_taken_i || pend_q);
    end
  end

  // Stage enables/bubbles: freeze beats load-use, flush overrides the IF_ID hold.
  always_comb begin
    pc_en_c             = !freeze_c && !load_use_c;
    bus.pc_en_o         = pc_en_c;
    bus.if_id_en_o      = !freeze_c && (!load_use_c || flush_c);
    bus.if_id_flush_o   = flush_c;
    bus.id_ex_en_o      = !freeze_c;
    bus.id_ex_bubble_o  = !freeze_c && load_use_c;
    bus.ex_mem_en_o     = !freeze_c;
    bus.mem_wb_bubble_o = freeze_c;
  end

  // Next-state, wait counter and pending-flush tracking.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pend_d  = pend_q;
    if (freeze_c) begin
      pend_d = pend_q || bus.branch_taken_i;
    end else begin
      pend_d = 1'b0;
    end
    case (state_q)
      RUN: begin
        if (bus.dmem_req_i && !bus.dmem_ready_i) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready_i) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      wait_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
    end
  end

  // Saturating stall-cycle counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (!pc_en_c && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (state_d == ERROR) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.stall_cnt_o = stall_q;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for single-cycle decode,
// hand sequences for memory wait, deferred flush, timeout and saturation.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;

  pipe_hazard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  // inputs: memread, id_ex_rt, if_id_rs, if_id_rt, branch, req, ready
  // expected: {pc_en, if_id_en, flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble}
  typedef struct {
    logic       memread;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[11];
  int total = 0;
  int bad = 0;
  int exp_stall = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.pc_en_o, bus.if_id_en_o, bus.if_id_flush_o, bus.id_ex_en_o,
            bus.id_ex_bubble_o, bus.ex_mem_en_o, bus.mem_wb_bubble_o};
  endfunction

  task automatic set_in(input logic m, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic br, input logic req, input logic rdy);
    bus.id_ex_memread_i = m;
    bus.id_ex_rt_i      = ert;
    bus.if_id_rs_i      = rs;
    bus.if_id_rt_i      = rt;
    bus.branch_taken_i  = br;
    bus.dmem_req_i      = req;
    bus.dmem_ready_i    = rdy;
  endtask

  // One cycle: drive at negedge, check decode, then check registered outputs after the edge.
  task automatic step(input string name, input logic m, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic br,
                      input logic req, input logic rdy, input logic [6:0] exp,
                      input logic exp_err);
    @(negedge clk_i);
    set_in(m, ert, rs, rt, br, req, rdy);
    #1;
    chk({name, "_ctl"}, int'(outs()), int'(exp));
    if (!exp[6] && exp_stall < 15) exp_stall++;
    @(posedge clk_i);
    #1;
    chk({name, "_cnt"}, int'(bus.stall_cnt_o), exp_stall);
    chk({name, "_err"}, int'(bus.err_o), int'(exp_err));
  endtask

  localparam logic [6:0] IDLE   = 7'b1101010;
  localparam logic [6:0] LU     = 7'b0001110;
  localparam logic [6:0] FRZ    = 7'b0000001;
  localparam logic [6:0] FL     = 7'b1111010;
  localparam logic [6:0] FL_LU  = 7'b0111110;

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    vecs[0]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE,  "idle"};
    vecs[1]  = '{1, 5'd5, 5'd5, 5'd3, 0, 0, 0, LU,    "lu_rs"};
    vecs[2]  = '{1, 5'd5, 5'd2, 5'd5, 0, 0, 0, LU,    "lu_rt"};
    vecs[3]  = '{1, 5'd0, 5'd0, 5'd0, 0, 0, 0, IDLE,  "lu_r0"};
    vecs[4]  = '{0, 5'd5, 5'd5, 5'd5, 0, 0, 0, IDLE,  "no_load"};
    vecs[5]  = '{1, 5'd7, 5'd6, 5'd8, 0, 0, 0, IDLE,  "no_match"};
    vecs[6]  = '{0, 5'd0, 5'd0, 5'd0, 1, 0, 0, FL,    "branch"};
    vecs[7]  = '{1, 5'd9, 5'd9, 5'd1, 1, 0, 0, FL_LU, "br_lu"};
    vecs[8]  = '{0, 5'd0, 5'd0, 5'd0, 0, 1, 1, IDLE,  "req_rdy"};
    vecs[9]  = '{0, 5'd0, 5'd0, 5'd0, 0, 0, 1, IDLE,  "rdy_noreq"};
    vecs[10] = '{1, 5'd4, 5'd1, 5'd4, 0, 1, 1, LU,    "req_rdy_lu"};

    // Reset held with random inputs: idle controls, counters clear.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      set_in(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      chk("rst_ctl", int'(outs()), int'(IDLE));
      chk("rst_cnt", int'(bus.stall_cnt_o), 0);
      chk("rst_err", int'(bus.err_o), 0);
    end
    @(negedge clk_i);
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst_n_i = 1'b1;

    // Single-cycle decode in RUN.
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].name, vecs[i].memread, vecs[i].ex_rt, vecs[i].id_rs, vecs[i].id_rt,
           vecs[i].br, vecs[i].req, vecs[i].rdy, vecs[i].exp, 1'b0);
    end

    // Memory wait: 3 frozen cycles, branch in the 2nd deferred, load-use masked by freeze.
    step("mw1", 0, 0, 0, 0, 0, 1, 0, FRZ, 1'b0);
    step("mw2", 0, 0, 0, 0, 1, 1, 0, FRZ, 1'b0);
    step("mw3", 1, 3, 3, 0, 0, 1, 0, FRZ, 1'b0);
    step("mw_rel", 0, 0, 0, 0, 0, 1, 1, FL, 1'b0);
    step("mw_after", 0, 0, 0, 0, 0, 0, 0, IDLE, 1'b0);

    // Timeout: ready never arrives; ERROR after TIMEOUT frozen cycles, then sticky.
    step("to1", 0, 0, 0, 0, 0, 1, 0, FRZ, 1'b0);
    step("to2", 0, 0, 0, 0, 0, 1, 0, FRZ, 1'b0);
    step("to3", 0, 0, 0, 0, 1, 1, 0, FRZ, 1'b0);
    step("to4", 0, 0, 0, 0, 0, 1, 0, FRZ, 1'b1);
    step("err1", 0, 0, 0, 0, 0, 1, 1, FRZ, 1'b1);
    step("err2", 0, 0, 0, 0, 0, 0, 0, FRZ, 1'b1);

    // Async reset pulse mid-ERROR: immediate idle, pending flush dropped.
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    chk("arst_ctl", int'(outs()), int'(IDLE));
    chk("arst_err", int'(bus.err_o), 0);
    chk("arst_cnt", int'(bus.stall_cnt_o), 0);
    exp_stall = 0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step("post_rst", 0, 0, 0, 0, 0, 0, 0, IDLE, 1'b0);

    // Saturation: 20 load-use stalls stop the counter at 15.
    for (int i = 0; i < 20; i++) begin
      step("sat", 1, 6, 6, 0, 0, 0, 0, LU, 1'b0);
    end
    chk("sat_final", int'(bus.stall_cnt_o), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
